// File: rtl/timer_deadline_scheduler.sv
// timer_deadline_scheduler
//   Holds NR_SLOTS 64-bit deadlines against a free-running mtime. A scan
//   pointer visits one slot per cycle: armed slots whose deadline has been
//   reached fire (expired_o pulse, sticky pending bit), and the rest are
//   folded into a running minimum. That minimum is published on
//   next_*_o once per full pass. Host updates go through a req/gnt
//   handshake that takes the FSM through a one-cycle UPDATE state.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   time_i              current mtime (unsigned 64-bit)
//   req_i/gnt_o         slot update request / one-cycle accept pulse
//   arm_i, slot_i,      update payload: arm (1) or disarm (0) slot_i,
//   deadline_i            storing deadline_i on arm
//   ack_i               per-slot clear of pending_o
//   expired_o           per-slot one-cycle expiry pulse
//   pending_o, irq_o    sticky expiry flags and their OR
//   next_valid_o,       earliest armed deadline seen during the last
//   next_deadline_o,      complete pass and the slot holding it
//   next_slot_o
module timer_deadline_scheduler #(
    parameter int NR_SLOTS = 4,
    parameter int SW       = $clog2(NR_SLOTS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [63:0]         time_i,
    input  logic                req_i,
    input  logic                arm_i,
    input  logic [SW-1:0]       slot_i,
    input  logic [63:0]         deadline_i,
    output logic                gnt_o,
    input  logic [NR_SLOTS-1:0] ack_i,
    output logic [NR_SLOTS-1:0] expired_o,
    output logic [NR_SLOTS-1:0] pending_o,
    output logic                irq_o,
    output logic                next_valid_o,
    output logic [63:0]         next_deadline_o,
    output logic [SW-1:0]       next_slot_o
);

    typedef enum logic {SCAN, UPDATE} state_e;

    localparam logic [SW-1:0] LAST_IDX = SW'(NR_SLOTS - 1);

    state_e              state_q, state_d;
    logic [SW-1:0]       idx_q, idx_d;
    logic [NR_SLOTS-1:0] armed_q, armed_d;
    logic [NR_SLOTS-1:0] pending_q, pending_d;
    logic [63:0]         dl_q [NR_SLOTS];
    logic                dl_we;

    // running minimum of the pass in progress
    logic                min_vld_q, min_vld_d;
    logic [63:0]         min_val_q, min_val_d;
    logic [SW-1:0]       min_slot_q, min_slot_d;

    // published result of the last complete pass
    logic                nxt_vld_q, nxt_vld_d;
    logic [63:0]         nxt_val_q, nxt_val_d;
    logic [SW-1:0]       nxt_slot_q, nxt_slot_d;

    // minimum including the slot evaluated this cycle
    logic                f_vld;
    logic [63:0]         f_val;
    logic [SW-1:0]       f_slot;

    logic                expire;
    logic                gnt;
    logic [NR_SLOTS-1:0] exp_mask;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        armed_d    = armed_q;
        min_vld_d  = min_vld_q;
        min_val_d  = min_val_q;
        min_slot_d = min_slot_q;
        nxt_vld_d  = nxt_vld_q;
        nxt_val_d  = nxt_val_q;
        nxt_slot_d = nxt_slot_q;
        f_vld      = min_vld_q;
        f_val      = min_val_q;
        f_slot     = min_slot_q;
        expire     = 1'b0;
        exp_mask   = '0;
        gnt        = 1'b0;
        dl_we      = 1'b0;

        case (state_q)
            SCAN: begin
                expire = armed_q[idx_q] && (time_i >= dl_q[idx_q]);
                if (expire) begin
                    exp_mask[idx_q] = 1'b1;
                    armed_d[idx_q]  = 1'b0;
                end else if (armed_q[idx_q] && (!min_vld_q || dl_q[idx_q] < min_val_q)) begin
                    // strict compare: slots are visited in ascending order,
                    // so an equal later deadline never displaces an earlier slot
                    f_vld  = 1'b1;
                    f_val  = dl_q[idx_q];
                    f_slot = idx_q;
                end
                min_vld_d  = f_vld;
                min_val_d  = f_val;
                min_slot_d = f_slot;
                if (idx_q == LAST_IDX) begin
                    // an empty pass publishes valid=0, all-ones, slot 0
                    nxt_vld_d  = f_vld;
                    nxt_val_d  = f_val;
                    nxt_slot_d = f_slot;
                    min_vld_d  = 1'b0;
                    min_val_d  = '1;
                    min_slot_d = '0;
                end
                idx_d = idx_q + 1'b1;   // power-of-two slot count wraps for free
                if (req_i) state_d = UPDATE;
            end
            UPDATE: begin
                gnt = 1'b1;
                if (arm_i) begin
                    dl_we           = 1'b1;
                    armed_d[slot_i] = 1'b1;
                end else begin
                    armed_d[slot_i] = 1'b0;
                end
                // restart the pass so the published minimum reflects the update
                state_d    = SCAN;
                idx_d      = '0;
                min_vld_d  = 1'b0;
                min_val_d  = '1;
                min_slot_d = '0;
            end
            default: state_d = SCAN;
        endcase

        // a new expiry wins over an ack of the same slot
        pending_d = (pending_q & ~ack_i) | exp_mask;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SCAN;
            idx_q      <= '0;
            armed_q    <= '0;
            pending_q  <= '0;
            min_vld_q  <= 1'b0;
            min_val_q  <= '1;
            min_slot_q <= '0;
            nxt_vld_q  <= 1'b0;
            nxt_val_q  <= '1;
            nxt_slot_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            min_vld_q  <= min_vld_d;
            min_val_q  <= min_val_d;
            min_slot_q <= min_slot_d;
            nxt_vld_q  <= nxt_vld_d;
            nxt_val_q  <= nxt_val_d;
            nxt_slot_q <= nxt_slot_d;
        end
    end

    // deadline storage is not reset; it is only read while armed
    always_ff @(posedge clk_i) begin
        if (!rst_i && dl_we) dl_q[slot_i] <= deadline_i;
    end

    // reset masks the pulses so an in-flight request is dropped silently
    assign gnt_o           = gnt & ~rst_i;
    assign expired_o       = exp_mask & {NR_SLOTS{~rst_i}};
    assign pending_o       = pending_q;
    assign irq_o           = |pending_q;
    assign next_valid_o    = nxt_vld_q;
    assign next_deadline_o = nxt_val_q;
    assign next_slot_o     = nxt_slot_q;

endmodule

// File: tb/tb_timer_deadline_scheduler.sv
// Testbench for timer_deadline_scheduler: directed scenarios followed by a
// randomized phase, every cycle compared against a queue-based model.
module tb_timer_deadline_scheduler;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   tm;
    logic          req;
    logic          arm;
    logic [SW-1:0] slot;
    logic [63:0]   dl;
    logic          gnt_o;
    logic [N-1:0]  ack;
    logic [N-1:0]  expired_o;
    logic [N-1:0]  pending_o;
    logic          irq_o;
    logic          next_valid_o;
    logic [63:0]   next_deadline_o;
    logic [SW-1:0] next_slot_o;

    timer_deadline_scheduler #(.NR_SLOTS(N), .SW(SW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .time_i         (tm),
        .req_i          (req),
        .arm_i          (arm),
        .slot_i         (slot),
        .deadline_i     (dl),
        .gnt_o          (gnt_o),
        .ack_i          (ack),
        .expired_o      (expired_o),
        .pending_o      (pending_o),
        .irq_o          (irq_o),
        .next_valid_o   (next_valid_o),
        .next_deadline_o(next_deadline_o),
        .next_slot_o    (next_slot_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: per-slot arrays, a pointer that walks the slots, and
    // a queue of the deadlines that survived the current pass; the minimum
    // is picked from the queue only when the pass completes
    typedef struct {
        int          slot;
        logic [63:0] dl;
    } surv_t;

    bit          m_upd;
    int          m_idx;
    bit          m_armed [N];
    logic [63:0] m_dl    [N];
    logic [N-1:0] m_pend;
    surv_t       surv [$];
    bit          m_nv;
    logic [63:0] m_nd;
    int          m_ns;

    logic [N-1:0] last_exp;
    bit           last_gnt;
    int           exp_cnt [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_upd = 1'b0;
        m_idx = 0;
        foreach (m_armed[i]) m_armed[i] = 1'b0;
        m_pend = '0;
        surv.delete();
        m_nv = 1'b0;
        m_nd = ONES;
        m_ns = 0;
    endtask

    task automatic clr_cnt();
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
    endtask

    // one clock: compare at negedge, advance the model, then step past posedge
    task automatic cyc();
        logic [N-1:0] e_exp;
        bit           e_gnt;
        bit           hit;
        int           best;
        @(negedge clk);
        e_gnt = m_upd && !rst;
        hit   = !m_upd && m_armed[m_idx] && (tm >= m_dl[m_idx]);
        e_exp = (hit && !rst) ? (N'(1) << m_idx) : '0;
        chk("gnt",           gnt_o,           e_gnt);
        chk("expired",       expired_o,       e_exp);
        chk("pending",       pending_o,       m_pend);
        chk("irq",           irq_o,           |m_pend);
        chk("next_valid",    next_valid_o,    m_nv);
        chk("next_deadline", next_deadline_o, m_nd);
        chk("next_slot",     next_slot_o,     m_ns);
        last_exp = expired_o;
        last_gnt = gnt_o;
        for (int i = 0; i < N; i++) if (expired_o[i] === 1'b1) exp_cnt[i]++;

        if (rst) begin
            model_reset();
        end else if (m_upd) begin
            if (arm) begin
                m_armed[slot] = 1'b1;
                m_dl[slot]    = dl;
            end else begin
                m_armed[slot] = 1'b0;
            end
            m_pend = m_pend & ~ack;
            m_upd  = 1'b0;
            m_idx  = 0;
            surv.delete();
        end else begin
            m_pend = m_pend & ~ack;
            if (hit) begin
                m_armed[m_idx] = 1'b0;
                m_pend[m_idx]  = 1'b1;
            end else if (m_armed[m_idx]) begin
                surv.push_back('{m_idx, m_dl[m_idx]});
            end
            if (m_idx == N - 1) begin
                best = -1;
                foreach (surv[k]) if (best < 0 || surv[k].dl < surv[best].dl) best = k;
                if (best < 0) begin
                    m_nv = 1'b0; m_nd = ONES; m_ns = 0;
                end else begin
                    m_nv = 1'b1; m_nd = surv[best].dl; m_ns = surv[best].slot;
                end
                surv.delete();
            end
            m_idx = (m_idx + 1) % N;
            if (req) m_upd = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // host request, held until granted (bounded)
    task automatic do_req(input bit a, input int s, input logic [63:0] d);
        req  = 1'b1;
        arm  = a;
        slot = SW'(s);
        dl   = d;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (last_gnt) break;
        end
        chk("req_granted", last_gnt, 1);
        req = 1'b0;
    endtask

    task automatic pass();
        repeat (N) cyc();
    endtask

    initial begin
        rst = 1'b1; tm = '0; req = 1'b0; arm = 1'b0; slot = '0; dl = '0; ack = '0;
        clr_cnt();
        @(posedge clk);
        #1;
        model_reset();
        cyc();
        rst = 1'b0;
        chk("rst_next_deadline", next_deadline_o, ONES);
        chk("rst_next_valid",    next_valid_o,    0);
        chk("rst_pending",       pending_o,       0);

        // basic arm
        tm = 64'd100;
        do_req(1'b1, 2, 64'd500);
        pass();
        chk("arm_valid",    next_valid_o,    1);
        chk("arm_deadline", next_deadline_o, 64'd500);
        chk("arm_slot",     next_slot_o,     2);

        // expiry, ack, empty pass
        clr_cnt();
        tm = 64'd500;
        pass();
        chk("exp_pulses",  exp_cnt[2], 1);
        chk("exp_pending", pending_o,  4'b0100);
        chk("exp_irq",     irq_o,      1);
        ack = 4'b0100;
        cyc();
        ack = '0;
        chk("ack_irq", irq_o, 0);
        pass();
        chk("empty_valid",    next_valid_o,    0);
        chk("empty_deadline", next_deadline_o, ONES);

        // minimum with a tie, then disarm the winner
        tm = 64'd0;
        do_req(1'b1, 1, 64'd300);
        do_req(1'b1, 3, 64'd300);
        pass();
        chk("tie_slot",     next_slot_o,     1);
        chk("tie_deadline", next_deadline_o, 64'd300);
        do_req(1'b0, 1, 64'd0);
        pass();
        chk("disarm_slot", next_slot_o, 3);

        // deadline already in the past
        clr_cnt();
        tm = 64'd50;
        do_req(1'b1, 0, 64'd10);
        pass();
        chk("past_pulses",  exp_cnt[0],   1);
        chk("past_pending", pending_o[0], 1);
        chk("past_slot",    next_slot_o,  3);

        // expiry and ack on the same slot in the same cycle
        ack = 4'b0001;
        do_req(1'b1, 0, 64'd10);
        for (int i = 0; i < N; i++) begin
            cyc();
            if (last_exp[0]) break;
        end
        ack = '0;
        chk("setack_expired", last_exp[0],  1);
        chk("setack_pending", pending_o[0], 1);

        // all-ones deadline
        ack = '1;
        cyc();
        ack = '0;
        clr_cnt();
        tm = ONES - 64'd1;
        do_req(1'b1, 2, ONES);
        pass();
        chk("ones_noexp",    exp_cnt[2],      0);
        chk("ones_valid",    next_valid_o,    1);
        chk("ones_deadline", next_deadline_o, ONES);
        chk("ones_slot",     next_slot_o,     2);
        tm = ONES;
        pass();
        chk("ones_exp", exp_cnt[2], 1);

        // reset while in UPDATE
        ack = '1;
        cyc();
        ack = '0;
        tm   = 64'd0;
        req  = 1'b1; arm = 1'b1; slot = 2'd1; dl = 64'd77;
        cyc();
        rst = 1'b1;
        cyc();
        chk("rstreq_gnt", last_gnt, 0);
        rst = 1'b0;
        req = 1'b0;
        cyc();
        chk("rstreq_pending",  pending_o,       0);
        chk("rstreq_irq",      irq_o,           0);
        chk("rstreq_valid",    next_valid_o,    0);
        chk("rstreq_deadline", next_deadline_o, ONES);
        chk("rstreq_slot",     next_slot_o,     0);
        pass();
        chk("rstreq_dropped", next_valid_o, 0);

        // randomized traffic
        tm = 64'd1000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                req = 1'b0;
            end else begin
                rst = 1'b0;
                if (!req && $urandom_range(0, 5) == 0) begin
                    req  = 1'b1;
                    arm  = ($urandom_range(0, 3) != 0);
                    slot = SW'($urandom_range(0, N - 1));
                    case ($urandom_range(0, 9))
                        0:       dl = ONES;
                        1, 2:    dl = tm - 64'($urandom_range(0, 20));
                        default: dl = tm + 64'($urandom_range(0, 60));
                    endcase
                end
            end
            ack = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            tm  = tm + 64'($urandom_range(0, 3));
            cyc();
            if (last_gnt) req = 1'b0;
        end
        rst = 1'b0;
        req = 1'b0;
        ack = '0;
        pass();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_deadline_scheduler.md
TIMER_DEADLINE_SCHEDULER -- requirements
Module: timer_deadline_scheduler

Interface
REQ-001 SHALL have parameter NR_SLOTS, default 4: number of deadline slots; a power of two, at least 2.
REQ-002 SHALL have parameter SW, default $clog2(NR_SLOTS): width of the slot index.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port time_i, input, 64: global mtime value, unsigned.
REQ-006 SHALL have port req_i, input, 1: host slot-update request; held until gnt_o.
REQ-007 SHALL have port arm_i, input, 1: 1 = arm the slot with deadline_i, 0 = disarm it; stable while req_i is high.
REQ-008 SHALL have port slot_i, input, SW: target slot of the request; stable while req_i is high.
REQ-009 SHALL have port deadline_i, input, 64: deadline to store on arm; stable while req_i is high.
REQ-010 SHALL have port gnt_o, output, 1: one-cycle pulse that accepts the request.
REQ-011 SHALL have port ack_i, input, NR_SLOTS: per-slot clear of the pending flag.
REQ-012 SHALL have port expired_o, output, NR_SLOTS: one-cycle pulse per slot on expiry.
REQ-013 SHALL have port pending_o, output, NR_SLOTS: sticky expired flags.
REQ-014 SHALL have port irq_o, output, 1: OR of pending_o.
REQ-015 SHALL have port next_valid_o, output, 1: at least one slot was armed at the end of the last pass.
REQ-016 SHALL have port next_deadline_o, output, 64: earliest armed deadline of the last pass.
REQ-017 SHALL have port next_slot_o, output, SW: slot that holds next_deadline_o.

Function
REQ-018 SHALL hold, per slot, a 64-bit deadline register and an armed bit.
REQ-019 SHALL implement an FSM with states SCAN and UPDATE.
REQ-020 SHALL, in SCAN, evaluate one slot per cycle at scan index idx, with idx wrapping from NR_SLOTS-1 to 0.
REQ-021 SHALL treat slot idx as expiring when it is armed and time_i >= deadline[idx] (unsigned 64-bit compare, no wrap handling).
REQ-022 SHALL, when a slot expires: pulse expired_o[idx] in that cycle, clear armed[idx], and set pending[idx] at the clock edge.
REQ-023 SHALL fold each armed, non-expiring slot into a running minimum (value, slot), with ties resolved to the lower slot index.
REQ-024 SHALL, at the edge after evaluating idx = NR_SLOTS-1, copy the running minimum to next_deadline_o / next_slot_o / next_valid_o.
REQ-025 SHALL, after that copy, reset the running minimum to "none".
REQ-026 SHALL drive next_valid_o = 0 and next_deadline_o = all ones when no slot is armed at the end of a pass.
REQ-027 SHALL, when req_i is high in SCAN, still evaluate the current slot, then move to UPDATE.
REQ-028 SHALL, in UPDATE, pulse gnt_o for exactly one cycle.
REQ-029 SHALL, in UPDATE on arm, write deadline[slot_i] = deadline_i and set armed[slot_i].
REQ-030 SHALL, in UPDATE on disarm, clear armed[slot_i] and leave the deadline unchanged.
REQ-031 SHALL, on leaving UPDATE, set idx to 0, clear the running minimum and return to SCAN; no slot is evaluated in UPDATE.
REQ-032 SHALL give request latency: req_i first seen high in cycle t gives gnt_o in cycle t+1 and the new state visible from t+2.
REQ-033 SHALL not clear the pending bit on disarm.
REQ-034 SHALL give pending set priority over ack_i in the same cycle.
REQ-035 SHALL let ack_i clear any number of pending bits at once.
REQ-036 SHALL allow an arm whose deadline is at or below time_i; that slot expires within NR_SLOTS cycles after gnt_o.
REQ-037 SHALL treat an armed deadline of 2^64-1 normally: it expires only when time_i equals 2^64-1.
REQ-038 SHALL assert irq_o combinationally whenever any pending bit is set.

Reset
REQ-039 SHALL, while rst_i is high at a clock edge, force: state SCAN, idx 0, all armed bits and pending bits 0, running minimum none.
REQ-040 SHALL, while rst_i is high at a clock edge, force: gnt_o 0, expired_o 0, irq_o 0, next_valid_o 0, next_deadline_o all ones, next_slot_o 0.
REQ-041 SHALL let reset take priority over an in-flight request; the request is dropped and no gnt_o is issued.
REQ-042 SHALL not reset the deadline registers; their contents are don't-care until armed.

Verification
REQ-043 SHALL cover basic arm: NR_SLOTS=4, time_i=100, arm slot 2 at 500 -> gnt_o 1 cycle after req_i; after one full pass next_valid_o=1, next_deadline_o=500, next_slot_o=2.
REQ-044 SHALL cover expiry: time_i stepped to 500 -> expired_o[2] single pulse, pending_o=4'b0100, irq_o=1; ack_i[2] -> irq_o=0 next cycle; next_valid_o=0 after the next pass.
REQ-045 SHALL cover min and tie: arm slot 1 at 300 and slot 3 at 300, time_i=0 -> next_slot_o=1; disarm slot 1 -> next_slot_o=3 after one pass.
REQ-046 SHALL cover past deadline: arm slot 0 at 10 with time_i=50 -> expired_o[0] within 4 cycles of gnt_o; armed cleared, pending_o[0]=1.
REQ-047 SHALL cover simultaneous set and ack: re-arm slot 0 in the past while holding ack_i[0] across its expiry cycle -> pending_o[0] stays 1.
REQ-048 SHALL cover reset mid-request: rst_i asserted while state is UPDATE -> no gnt_o; all outputs at reset values the next cycle.
